riscv_lsu_ctrl: RTL and testbench

//  Load/store sequencer in front of the memory-access (MA) stage.
//  - Accepts one load/store per transaction from EX.
//  - Drives a req/gnt/rvalid data-memory port.
//  - Stalls the pipeline while a transaction is outstanding.
//  - Hands the aligned, sign/zero-extended load result and rd to MA.

---
 rtl/riscv_pkg.sv | 24 ++
 rtl/riscv_lsu_align.sv | 44 ++++
 rtl/riscv_lsu_ctrl.sv | 173 +++++++++++++++++
 tb/tb_riscv_lsu_ctrl.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32 constants and LSU types used by the load/store sequencer.
package riscv_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {IDLE, REQ, WAIT} lsu_state_t;

  // funct3[1:0] carries the access size for both loads and stores
  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] off);
    case (funct3[1:0])
      2'b01:   return off[0];
      2'b10:   return off != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/riscv_lsu_align.sv
// Combinational byte-lane steering: byte enables, store data shift and
// load data extraction with sign/zero extension.
module riscv_lsu_align
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]        i_funct3,
  input  logic [1:0]        i_off,
  input  logic [XLEN-1:0]   i_wdata,
  input  logic [XLEN-1:0]   i_rdata,
  output logic [XLEN/8-1:0] o_be,
  output logic [XLEN-1:0]   o_wdata,
  output logic [XLEN-1:0]   o_ldata
);

  localparam int BW = XLEN / 8;

  logic [4:0]      w_shamt;
  logic [XLEN-1:0] w_rsh;
  logic            w_uns;

  assign w_shamt = {i_off, 3'b000};
  assign w_rsh   = i_rdata >> w_shamt;
  assign o_wdata = i_wdata << w_shamt;
  assign w_uns   = i_funct3[2];

  always_comb begin
    o_be    = '1;
    o_ldata = w_rsh;
    case (i_funct3)
      F3_LB, F3_LBU: begin
        o_be    = BW'(1) << i_off;
        o_ldata = {{(XLEN-8){~w_uns & w_rsh[7]}}, w_rsh[7:0]};
      end
      F3_LH, F3_LHU: begin
        o_be    = BW'(3) << i_off;
        o_ldata = {{(XLEN-16){~w_uns & w_rsh[15]}}, w_rsh[15:0]};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/riscv_lsu_ctrl.sv
// Load/store sequencer between EX/MA and a req/gnt/rvalid data memory port.
// Optional RISCV_LSU_MISALIGN_EN: fault misaligned ops instead of truncating the offset.
module riscv_lsu_ctrl
  import riscv_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int REGN = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      ex_valid,
  output logic                      ex_ready,
  input  logic                      ex_load,
  input  logic                      ex_store,
  input  logic [2:0]                ex_funct3,
  input  logic [XLEN-1:0]           ex_addr,
  input  logic [XLEN-1:0]           ex_wdata,
  input  logic [$clog2(REGN)-1:0]   ex_rd,
  output logic                      mem_req,
  input  logic                      mem_gnt,
  output logic                      mem_we,
  output logic [XLEN/8-1:0]         mem_be,
  output logic [XLEN-1:0]           mem_addr,
  output logic [XLEN-1:0]           mem_wdata,
  input  logic                      mem_rvalid,
  input  logic [XLEN-1:0]           mem_rdata,
  output logic                      stall,
  output logic                      ma_valid,
  output logic                      ma_memfetch,
  output logic [XLEN-1:0]           ma_memi,
  output logic [$clog2(REGN)-1:0]   ma_rd,
  output logic                      misalign
);

  localparam int REGA = $clog2(REGN);

  lsu_state_t r_state, w_next;

  logic            r_load;
  logic [2:0]      r_funct3;
  logic [1:0]      r_off;
  logic [REGA-1:0] r_rd;

  logic              w_issue;
  logic              w_done;
  logic [1:0]        w_off;
  logic [2:0]        w_sel_f3;
  logic [1:0]        w_sel_off;
  logic [XLEN/8-1:0] w_be;
  logic [XLEN-1:0]   w_wdata;
  logic [XLEN-1:0]   w_ldata;

`ifdef RISCV_LSU_MISALIGN_EN
  logic w_fault;
  assign w_off = ex_addr[1:0];
`else
  // Offset bits an access cannot use are dropped so the op is always issued
  always_comb begin
    case (ex_funct3[1:0])
      2'b00:   w_off = ex_addr[1:0];
      2'b01:   w_off = {ex_addr[1], 1'b0};
      default: w_off = 2'b00;
    endcase
  end
  assign misalign = 1'b0;
`endif

  assign ex_ready = (r_state == IDLE);
  assign stall    = (r_state != IDLE);

  // Store lanes come from the EX op at accept; load extraction uses the latched op
  assign w_sel_f3  = (r_state == IDLE) ? ex_funct3 : r_funct3;
  assign w_sel_off = (r_state == IDLE) ? w_off : r_off;

  riscv_lsu_align #(.XLEN(XLEN)) u_align (
    .i_funct3 (w_sel_f3),
    .i_off    (w_sel_off),
    .i_wdata  (ex_wdata),
    .i_rdata  (mem_rdata),
    .o_be     (w_be),
    .o_wdata  (w_wdata),
    .o_ldata  (w_ldata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    w_issue = 1'b0;
    w_done  = 1'b0;
`ifdef RISCV_LSU_MISALIGN_EN
    w_fault = 1'b0;
`endif
    case (r_state)
      IDLE: begin
        if (ex_valid && (ex_load || ex_store)) begin
`ifdef RISCV_LSU_MISALIGN_EN
          if (is_misaligned(ex_funct3, ex_addr[1:0])) begin
            w_fault = 1'b1;
          end else begin
            w_issue = 1'b1;
            w_next  = REQ;
          end
`else
          w_issue = 1'b1;
          w_next  = REQ;
`endif
        end
      end
      REQ: begin
        if (mem_gnt) w_next = r_load ? WAIT : IDLE;
      end
      WAIT: begin
        if (mem_rvalid) begin
          w_done = 1'b1;
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_be      <= '0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      ma_valid    <= 1'b0;
      ma_memfetch <= 1'b0;
      ma_memi     <= '0;
      ma_rd       <= '0;
      r_load      <= 1'b0;
      r_funct3    <= 3'b000;
      r_off       <= 2'b00;
      r_rd        <= '0;
    end else begin
      ma_valid    <= 1'b0;
      ma_memfetch <= 1'b0;
      if (w_issue) begin
        mem_req   <= 1'b1;
        mem_we    <= ex_store;
        mem_be    <= w_be;
        mem_addr  <= {ex_addr[XLEN-1:2], 2'b00};
        mem_wdata <= w_wdata;
        r_load    <= ex_load;
        r_funct3  <= ex_funct3;
        r_off     <= w_off;
        r_rd      <= ex_rd;
      end else if (r_state == REQ && mem_gnt) begin
        mem_req <= 1'b0;
      end
      if (w_done) begin
        ma_valid    <= 1'b1;
        ma_memfetch <= 1'b1;
        ma_memi     <= w_ldata;
        ma_rd       <= r_rd;
      end
    end
  end

`ifdef RISCV_LSU_MISALIGN_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) misalign <= 1'b0;
    else        misalign <= w_fault;
  end
`endif

endmodule

// File: tb/tb_riscv_lsu_ctrl.sv
// Scoreboard bench for riscv_lsu_ctrl: expected requests and load results are
// queued at stimulus time and checked when the DUT produces them.
module tb_riscv_lsu_ctrl;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ex_valid = 1'b0, ex_ready, ex_load = 1'b0, ex_store = 1'b0;
  logic [2:0]  ex_funct3 = 3'b000;
  logic [31:0] ex_addr = '0, ex_wdata = '0;
  logic [4:0]  ex_rd = '0;
  logic        mem_req, mem_gnt = 1'b0, mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        stall, ma_valid, ma_memfetch, misalign;
  logic [31:0] ma_memi;
  logic [4:0]  ma_rd;

  always #5 clk = ~clk;

  riscv_lsu_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_load(ex_load), .ex_store(ex_store),
    .ex_funct3(ex_funct3), .ex_addr(ex_addr), .ex_wdata(ex_wdata), .ex_rd(ex_rd),
    .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_we(mem_we), .mem_be(mem_be),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .stall(stall), .ma_valid(ma_valid), .ma_memfetch(ma_memfetch), .ma_memi(ma_memi),
    .ma_rd(ma_rd), .misalign(misalign)
  );

  typedef struct { logic [31:0] addr; logic [3:0] be; logic [31:0] wdata; logic we; } req_t;
  typedef struct { logic [31:0] memi; logic [4:0] rd; } ld_t;

  req_t reqQ[$];
  ld_t  ldQ[$];
  req_t monReq;
  ld_t  monLd;
  int   nCompared = 0;
  int   nMismatch = 0;
  int   stallCnt = 0;
  int   reqCnt = 0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCompared++;
    if (obs !== exp) begin
      nMismatch++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (stall) stallCnt++;
    if (mem_req) reqCnt++;
    if (rst_n && mem_req && mem_gnt) begin
      checkOutput("req_expected", 32'(reqQ.size() > 0), 1);
      if (reqQ.size() > 0) begin
        monReq = reqQ.pop_front();
        checkOutput("mem_addr", mem_addr, monReq.addr);
        checkOutput("mem_be", {28'd0, mem_be}, {28'd0, monReq.be});
        checkOutput("mem_wdata", mem_wdata, monReq.wdata);
        checkOutput("mem_we", mem_we, monReq.we);
      end
    end
    if (ma_valid) begin
      checkOutput("ld_expected", 32'(ldQ.size() > 0), 1);
      if (ldQ.size() > 0) begin
        monLd = ldQ.pop_front();
        checkOutput("ma_memi", ma_memi, monLd.memi);
        checkOutput("ma_rd", {27'd0, ma_rd}, {27'd0, monLd.rd});
        checkOutput("ma_memfetch", ma_memfetch, 1);
      end
    end
  end

  task automatic waitReady();
    int guard = 0;
    @(posedge clk); #1;
    while (!ex_ready && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    checkOutput("ex_ready_before_op", ex_ready, 1);
  endtask

  task automatic driveOp(input logic isLoad, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [4:0] rd);
    ex_valid  = 1'b1;
    ex_load   = isLoad;
    ex_store  = !isLoad;
    ex_funct3 = f3;
    ex_addr   = addr;
    ex_wdata  = wdata;
    ex_rd     = rd;
  endtask

  task automatic applyStimulus(input logic isLoad, input logic [2:0] f3, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [4:0] rd,
                               input int gntDelay, input int rvDelay, input logic [31:0] rdata,
                               input logic [31:0] expAddr, input logic [3:0] expBe,
                               input logic [31:0] expWdata, input logic [31:0] expMemi,
                               input int expStall, input logic spoof);
    waitReady();
    driveOp(isLoad, f3, addr, wdata, rd);
    reqQ.push_back(req_t'{expAddr, expBe, expWdata, !isLoad});
    if (isLoad) ldQ.push_back(ld_t'{expMemi, rd});
    stallCnt = 0;
    reqCnt = 0;
    @(posedge clk); #1;
    ex_valid = spoof;
    if (spoof) begin
      ex_load = 1'b1; ex_store = 1'b0; ex_funct3 = F3_LW; ex_addr = 32'h0000_0F00;
    end
    checkOutput("ex_ready_after_accept", ex_ready, 0);
    mem_gnt = (gntDelay == 0);
    for (int i = 0; i < gntDelay; i++) begin
      checkOutput("req_held", mem_req, 1);
      checkOutput("addr_held", mem_addr, expAddr);
      @(posedge clk); #1;
    end
    ex_valid = 1'b0;
    mem_gnt = 1'b1;
    @(posedge clk); #1;
    mem_gnt = 1'b0;
    if (isLoad) begin
      for (int i = 1; i < rvDelay; i++) begin
        @(posedge clk); #1;
      end
      mem_rvalid = 1'b1;
      mem_rdata = rdata;
      @(posedge clk); #1;
      mem_rvalid = 1'b0;
    end
    @(negedge clk); #1;
    checkOutput("stall_cycles", stallCnt, expStall);
    checkOutput("req_cycles", reqCnt, gntDelay + 1);
  endtask

  task automatic applyMisalign(input logic isLoad, input logic [2:0] f3, input logic [31:0] addr);
    waitReady();
    driveOp(isLoad, f3, addr, 32'h0, 5'd1);
    @(posedge clk); #1;
    ex_valid = 1'b0;
    checkOutput("misalign_pulse", misalign, 1);
    checkOutput("misalign_no_req", mem_req, 0);
    checkOutput("misalign_idle", ex_ready, 1);
    @(posedge clk); #1;
    checkOutput("misalign_one_cycle", misalign, 0);
    checkOutput("misalign_no_req_later", mem_req, 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_mem_req", mem_req, 0);
    checkOutput("rst_ex_ready", ex_ready, 1);
    checkOutput("rst_stall", stall, 0);
    checkOutput("rst_ma_valid", ma_valid, 0);
    checkOutput("rst_misalign", misalign, 0);
    checkOutput("rst_mem_be", {28'd0, mem_be}, 0);
    checkOutput("rst_mem_addr", mem_addr, 0);
    checkOutput("rst_ma_memi", ma_memi, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // LW, zero-wait grant, data two cycles later
    applyStimulus(1, F3_LW, 32'h100, 32'h0, 5'd5, 0, 2, 32'hDEADBEEF,
                  32'h100, 4'hF, 32'h0, 32'hDEADBEEF, 3, 0);
    // Byte loads at the top lane, signed and unsigned
    applyStimulus(1, F3_LB, 32'h103, 32'h0, 5'd7, 0, 1, 32'h80123456,
                  32'h100, 4'b1000, 32'h0, 32'hFFFFFF80, 2, 0);
    applyStimulus(1, F3_LBU, 32'h103, 32'h0, 5'd8, 0, 1, 32'h80123456,
                  32'h100, 4'b1000, 32'h0, 32'h00000080, 2, 0);
    applyStimulus(1, F3_LHU, 32'h102, 32'h0, 5'd10, 1, 3, 32'h80001111,
                  32'h100, 4'b1100, 32'h0, 32'h00008000, 5, 0);
    // Stores: SH with delayed grant, SB in lane 1
    applyStimulus(0, F3_SH, 32'h102, 32'h1234, 5'd0, 3, 0, 32'h0,
                  32'h100, 4'b1100, 32'h12340000, 32'h0, 4, 0);
    applyStimulus(0, F3_SB, 32'h101, 32'hAB, 5'd0, 0, 0, 32'h0,
                  32'h100, 4'b0010, 32'h0000AB00, 32'h0, 1, 0);

    // EX op with neither flag is ignored
    waitReady();
    ex_valid = 1'b1; ex_load = 1'b0; ex_store = 1'b0; ex_addr = 32'h400;
    @(posedge clk); #1;
    ex_valid = 1'b0;
    checkOutput("ignored_no_req", mem_req, 0);
    checkOutput("ignored_ready", ex_ready, 1);

`ifdef RISCV_LSU_MISALIGN_EN
    applyMisalign(1, F3_LW, 32'h101);
    applyMisalign(1, F3_LH, 32'h103);
    applyMisalign(0, F3_SW, 32'h202);
`else
    applyStimulus(1, F3_LW, 32'h101, 32'h11223344, 5'd9, 0, 1, 32'hCAFEF00D,
                  32'h100, 4'hF, 32'h11223344, 32'hCAFEF00D, 2, 0);
    applyStimulus(1, F3_LH, 32'h103, 32'h0, 5'd11, 0, 1, 32'hF00D1234,
                  32'h100, 4'b1100, 32'h0, 32'hFFFFF00D, 2, 0);
`endif

    // Back-to-back SW then LW; a new op held during REQ must not be taken
    applyStimulus(0, F3_SW, 32'h200, 32'hA5A5A5A5, 5'd0, 2, 0, 32'h0,
                  32'h200, 4'hF, 32'hA5A5A5A5, 32'h0, 3, 1);
    applyStimulus(1, F3_LW, 32'h204, 32'h0, 5'd12, 0, 1, 32'h01020304,
                  32'h204, 4'hF, 32'h0, 32'h01020304, 2, 0);

    // Reset while in WAIT: no result, late rvalid ignored
    waitReady();
    driveOp(1, F3_LW, 32'h300, 32'h0, 5'd3);
    reqQ.push_back(req_t'{32'h300, 4'hF, 32'h0, 1'b0});
    @(posedge clk); #1;
    ex_valid = 1'b0;
    mem_gnt = 1'b1;
    @(posedge clk); #1;
    mem_gnt = 1'b0;
    checkOutput("stall_in_wait", stall, 1);
    rst_n = 1'b0;
    #1;
    checkOutput("rst_wait_mem_req", mem_req, 0);
    checkOutput("rst_wait_stall", stall, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("rst_wait_ready", ex_ready, 1);
    mem_rvalid = 1'b1;
    mem_rdata = 32'h12345678;
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
    checkOutput("late_rvalid_ignored", ma_valid, 0);
    checkOutput("late_rvalid_memi", ma_memi, 0);

    // Reset while a request is pending drops mem_req at once
    waitReady();
    driveOp(1, F3_LW, 32'h500, 32'h0, 5'd4);
    @(posedge clk); #1;
    ex_valid = 1'b0;
    checkOutput("req_pending", mem_req, 1);
    rst_n = 1'b0;
    #1;
    checkOutput("rst_req_mem_req", mem_req, 0);
    checkOutput("rst_req_ready", ex_ready, 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("no_result_after_reset", ma_valid, 0);

    checkOutput("req_queue_drained", reqQ.size(), 0);
    checkOutput("ld_queue_drained", ldQ.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end

endmodule
